// File: rtl/boseben_mem_pkg.sv
// Shared constants for the boseben main-memory model: word/address widths,
// default geometry and latency, and the two control-FSM state codes.
package boseben_mem_pkg;

    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 32;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int LATENCY_DEF    = 4;
    localparam int CNT_W          = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/boseben_sram_array.sv
// Single-port synchronous word array. Reads and writes never coincide, so the
// read port simply registers the addressed word whenever a read is requested.
module boseben_sram_array
    import boseben_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int INIT_ZERO  = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Contents survive reset; with INIT_ZERO cleared the power-up value is a don't-care.
    logic [WORD_W-1:0] mem_q [DEPTH] =
        '{default: (INIT_ZERO != 0) ? {WORD_W{1'b0}} : {WORD_W{1'bx}}};

    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/boseben_ram.sv
// Backing memory behind the set-associative cache: accepts one word request,
// commits writes / samples reads immediately, and signals completion LATENCY cycles later.
module boseben_ram
    import boseben_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int INIT_ZERO  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data_in,
    output logic [WORD_W-1:0] mem_data_out,
    output logic              mem_ready
);

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  op_read_q, op_read_d;
    logic [WORD_W-1:0]     data_out_q, data_out_d;
    logic                  ready_q, ready_d;

    logic                  accept_we;
    logic                  accept_re;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [WORD_W-1:0]     held_word;

    // Byte offset and bits above the array depth are don't-cares (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_W-1:DEPTH_LOG2+2], mem_addr[1:0]};
    assign word_idx         = mem_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_read_d  = op_read_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        accept_we  = 1'b0;
        accept_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_we) begin
                    accept_we = 1'b1;
                    op_read_d = 1'b0;
                    count_d   = CNT_W'(LATENCY - 1);
                    state_d   = BUSY;
                end else if (mem_re) begin
                    accept_re = 1'b1;
                    op_read_d = 1'b1;
                    count_d   = CNT_W'(LATENCY - 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    ready_d = 1'b1;
                    if (op_read_q) begin
                        data_out_d = held_word;
                    end
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_read_q  <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_read_q  <= op_read_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
        end
    end

    boseben_sram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_ZERO  (INIT_ZERO)
    ) u_array (
        .clk   (clk),
        .we    (accept_we),
        .re    (accept_re),
        .addr  (word_idx),
        .wdata (mem_data_in),
        .rdata (held_word)
    );

    assign mem_data_out = data_out_q;
    assign mem_ready    = ready_q;

endmodule

// File: tb/tb_boseben_ram.sv
// Self-checking bench for boseben_ram: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an edge-count based model.
module tb_boseben_ram;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ready;

    int compared   = 0;
    int mismatched = 0;
    bit chk_en     = 1'b0;

    boseben_ram #(
        .DEPTH_LOG2 (10),
        .LATENCY    (LAT),
        .INIT_ZERO  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Reference: a request accepted on edge N finishes on edge N+LAT; nothing is accepted meanwhile.
    logic [31:0] model_mem [DEPTH];
    int          edge_no   = 0;
    int          done_edge = 0;
    bit          m_busy    = 1'b0;
    bit          m_read    = 1'b0;
    logic [31:0] m_val     = '0;
    logic [31:0] exp_out   = '0;
    bit          exp_ready = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    = 1'b0;
            exp_out   = '0;
            exp_ready = 1'b0;
        end else begin
            edge_no   = edge_no + 1;
            exp_ready = 1'b0;
            if (m_busy) begin
                if (edge_no == done_edge) begin
                    exp_ready = 1'b1;
                    if (m_read) exp_out = m_val;
                    m_busy = 1'b0;
                end
            end else if (mem_we) begin
                model_mem[(mem_addr >> 2) % DEPTH] = mem_data_in;
                m_busy    = 1'b1;
                m_read    = 1'b0;
                done_edge = edge_no + LAT;
            end else if (mem_re) begin
                m_val     = model_mem[(mem_addr >> 2) % DEPTH];
                m_busy    = 1'b1;
                m_read    = 1'b1;
                done_edge = edge_no + LAT;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            compared++;
            if (mem_ready !== exp_ready) begin
                mismatched++;
                $display("[TB] FAIL cycle_ready @%0t: got %b, expected %b", $time, mem_ready, exp_ready);
            end
            compared++;
            if (mem_data_out !== exp_out) begin
                mismatched++;
                $display("[TB] FAIL cycle_data @%0t: got %h, expected %h", $time, mem_data_out, exp_out);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] exp_d, input logic exp_r);
        compared++;
        if (mem_data_out !== exp_d || mem_ready !== exp_r) begin
            mismatched++;
            $display("[TB] FAIL %s: got data=%h ready=%b, expected data=%h ready=%b",
                     name, mem_data_out, mem_ready, exp_d, exp_r);
        end
        compared++;
        if (exp_out !== exp_d) begin
            mismatched++;
            $display("[TB] FAIL %s_model: model data=%h, expected %h", name, exp_out, exp_d);
        end
    endtask

    task automatic checkLatency(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", name, got, want);
        end
    endtask

    // Present one request for exactly one acceptance edge, then drop it.
    task automatic applyStimulus(input logic we, input logic re,
                                 input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        mem_we = we; mem_re = re; mem_addr = addr; mem_data_in = data;
        @(posedge clk);
        #1;
        mem_we = 1'b0; mem_re = 1'b0;
    endtask

    task automatic waitReady(input string name, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 12) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mem_ready) found = 1'b1;
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no mem_ready, expected one within 12 cycles", name);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_data_in = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1 checkOutput("reset_state", 32'h0, 1'b0);

        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
        waitReady("write_104", c);
        checkLatency("write_104", c, 4);
        checkOutput("write_104_done", 32'h0, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0);
        waitReady("read_104", c);
        checkLatency("read_104", c, 4);
        checkOutput("read_104", 32'hDEAD_BEEF, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'h0000_0107, 32'h0);
        waitReady("read_107", c);
        checkOutput("read_107", 32'hDEAD_BEEF, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h1234_5678);
        waitReady("write_1000", c);
        applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h0);
        waitReady("read_alias", c);
        checkOutput("read_alias", 32'h1234_5678, 1'b1);

        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        waitReady("priority", c);
        checkOutput("priority_out_held", 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h0);
        waitReady("read_20", c);
        checkOutput("read_20", 32'hA5A5_A5A5, 1'b1);

        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h1111_1111);
        waitReady("write_40", c);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0);
        mem_we = 1'b1; mem_addr = 32'h0000_0040; mem_data_in = 32'h2222_2222;
        @(posedge clk);
        #1 mem_we = 1'b0;
        waitReady("busy_read", c);
        checkLatency("busy_read", c, 3);
        checkOutput("busy_read", 32'h1111_1111, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0);
        waitReady("reread_40", c);
        checkOutput("reread_40", 32'h1111_1111, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("reset_async", 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 checkOutput("no_ready_after_reset", 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h0);
        waitReady("read_after_reset", c);
        checkLatency("read_after_reset", c, 4);
        checkOutput("read_after_reset", 32'hDEAD_BEEF, 1'b1);

        // Random traffic over a few words with random alias bits, held levels and reset pulses.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            mem_we      = ($urandom_range(0, 3) == 0);
            mem_re      = ($urandom_range(0, 2) == 0);
            mem_addr    = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                          | 32'($urandom_range(0, 3));
            mem_data_in = $urandom;
            if ($urandom_range(0, 79) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(posedge clk);
        #1 mem_we = 1'b0; mem_re = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
